// File: rtl/hex_ctrl_pkg.sv
// Shared types, constants and helpers for the hex display update controller.
package hex_ctrl_pkg;

   localparam int unsigned DIGIT_W          = 4;
   localparam logic [3:0]  BYTEENABLE_DIGIT = 4'h1;
   localparam int unsigned ADDR_W           = 3;
   localparam int unsigned DATA_W           = 32;
   localparam int unsigned MAX_DIGITS       = 8;
   localparam int unsigned MAX_VALUE_W      = DIGIT_W * MAX_DIGITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      NEXT  = 2'd2
   } state_e;

   // One Avalon-MM write beat as presented to the display slave.
   typedef struct packed {
      logic                write;
      logic [ADDR_W-1:0]   address;
      logic [3:0]          byteenable;
      logic [DATA_W-1:0]   writedata;
   } avm_cmd_t;

   function automatic logic [DIGIT_W-1:0] nibble_at(input logic [MAX_VALUE_W-1:0] value,
                                                    input logic [ADDR_W-1:0]      k);
      return value[k*DIGIT_W +: DIGIT_W];
   endfunction

   // Command for digit k; a skipped digit keeps address/data but raises no write.
   function automatic avm_cmd_t digit_cmd(input logic [MAX_VALUE_W-1:0] value,
                                          input logic [ADDR_W-1:0]      k,
                                          input logic                   skip);
      avm_cmd_t cmd;
      cmd.write      = !skip;
      cmd.address    = k;
      cmd.byteenable = skip ? 4'h0 : BYTEENABLE_DIGIT;
      cmd.writedata  = {(DATA_W-DIGIT_W)'(0), nibble_at(value, k)};
      return cmd;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, cyclic.
import hex_ctrl_pkg::*;

module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   idx
);

   int unsigned      cand;
   logic [PTR_W-1:0] cand_idx;
   logic             found;

   always_comb begin
      grant    = '0;
      idx      = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = 32'(ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = PTR_W'(cand);
         if (en && !found && req[cand_idx]) begin
            grant[cand_idx] = 1'b1;
            idx             = cand_idx;
            found           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hex_display_update_ctrl.sv
// Round-robin Avalon-MM master pushing six-digit hex values to a display slave.
// Optional feature: define HEX_SKIP_UNCHANGED_EN to suppress writes of unchanged digits.
import hex_ctrl_pkg::*;

module hex_display_update_ctrl #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned DIGITS  = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*4*DIGITS-1:0]  req_data_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   output logic [2:0]                   avm_address_o,
   output logic [3:0]                   avm_byteenable_o,
   output logic                         avm_write_o,
   output logic [31:0]                  avm_writedata_o,
   input  logic                         avm_waitrequest_i,
   output logic                         busy_o
);

   localparam int unsigned VAL_W      = DIGIT_W * DIGITS;
   localparam int unsigned PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [2:0]  LAST_DIGIT = 3'(DIGITS - 1);

   state_e             state_q;
   logic [2:0]         digit_q;
   logic [VAL_W-1:0]   value_q;
   logic [PTR_W-1:0]   rr_ptr_q;
   avm_cmd_t           cmd_q;
   logic               busy_q;

   logic [NUM_REQ-1:0] grant;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   ptr_next;
   logic               accept;
   logic               done;
   logic [VAL_W-1:0]   win_data;
   logic [2:0]         next_digit;
   logic               skip_first;
   logic               skip_next;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req   (req_valid_i),
      .ptr   (rr_ptr_q),
      .en    (state_q == IDLE),
      .grant (grant),
      .idx   (grant_idx)
   );

   assign accept      = |grant;
   assign req_ready_o = grant;
   assign next_digit  = digit_q + 3'd1;
   assign ptr_next    = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
   // A suppressed digit completes in its slot regardless of the slave's stall.
   assign done        = !cmd_q.write || !avm_waitrequest_i;

   // Mux the granted requester's value.
   always_comb begin
      win_data = '0;
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
         if (grant[r]) win_data = req_data_i[r*VAL_W +: VAL_W];
      end
   end

`ifdef HEX_SKIP_UNCHANGED_EN
   logic [DIGITS-1:0][DIGIT_W-1:0] shadow_q;
   logic [DIGITS-1:0]              shadow_vld_q;

   assign skip_first = shadow_vld_q[0] && (shadow_q[0] == win_data[DIGIT_W-1:0]);
   assign skip_next  = shadow_vld_q[next_digit] &&
                       (shadow_q[next_digit] == nibble_at(MAX_VALUE_W'(value_q), next_digit));

   // Remember what the slave actually holds, one nibble per digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q     <= '0;
         shadow_vld_q <= '0;
      end else if (state_q == WRITE && cmd_q.write && !avm_waitrequest_i) begin
         shadow_q[digit_q]     <= cmd_q.writedata[DIGIT_W-1:0];
         shadow_vld_q[digit_q] <= 1'b1;
      end
   end
`else
   assign skip_first = 1'b0;
   assign skip_next  = 1'b0;
`endif

   // Update sequencer with registered Avalon outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         digit_q  <= '0;
         value_q  <= '0;
         rr_ptr_q <= '0;
         cmd_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  value_q  <= win_data;
                  digit_q  <= '0;
                  rr_ptr_q <= ptr_next;
                  cmd_q    <= digit_cmd(MAX_VALUE_W'(win_data), 3'd0, skip_first);
                  busy_q   <= 1'b1;
                  state_q  <= WRITE;
               end
            end
            WRITE: begin
               if (done) begin
                  if (digit_q == LAST_DIGIT) begin
                     cmd_q   <= '0;
                     state_q <= NEXT;
                  end else begin
                     digit_q <= next_digit;
                     cmd_q   <= digit_cmd(MAX_VALUE_W'(value_q), next_digit, skip_next);
                  end
               end
            end
            NEXT: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               cmd_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign avm_write_o      = cmd_q.write;
   assign avm_address_o    = cmd_q.address;
   assign avm_byteenable_o = cmd_q.byteenable;
   assign avm_writedata_o  = cmd_q.writedata;
   assign busy_o           = busy_q;

endmodule

// File: tb/tb_hex_display_update_ctrl.sv
// Directed self-checking bench for hex_display_update_ctrl (NUM_REQ=2, DIGITS=6).
module tb_hex_display_update_ctrl;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [47:0] req_data;
   logic [1:0]  req_ready;
   logic [2:0]  avm_address;
   logic [3:0]  avm_byteenable;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   hex_display_update_ctrl #(
      .NUM_REQ (2),
      .DIGITS  (6)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req_valid_i       (req_valid),
      .req_data_i        (req_data),
      .req_ready_o       (req_ready),
      .avm_address_o     (avm_address),
      .avm_byteenable_o  (avm_byteenable),
      .avm_write_o       (avm_write),
      .avm_writedata_o   (avm_writedata),
      .avm_waitrequest_i (avm_waitrequest),
      .busy_o            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int busy_cnt;
      int wr_cnt;
      int rdy1_cnt;
      logic [2:0] exp_addr;

      rst_n           = 1'b0;
      req_valid       = '0;
      req_data        = '0;
      avm_waitrequest = 1'b0;
      tick();
      tick();

      check_eq("rst_write",  32'(avm_write),      32'd0);
      check_eq("rst_addr",   32'(avm_address),    32'd0);
      check_eq("rst_be",     32'(avm_byteenable), 32'd0);
      check_eq("rst_wdata",  avm_writedata,       32'd0);
      check_eq("rst_busy",   32'(busy),           32'd0);
      check_eq("rst_ready",  32'(req_ready),      32'd0);
      rst_n = 1'b1;
      tick();

      // Single requester, no stall.
      req_valid = 2'b01;
      req_data  = {24'h0, 24'h543210};
      #1 check_eq("s1_ready", 32'(req_ready), 32'b01);
      busy_cnt = 0;
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 1) req_valid = 2'b00;
         busy_cnt += int'(busy);
         if (c <= 6) begin
            check_eq($sformatf("s1_write_c%0d", c), 32'(avm_write),   32'd1);
            check_eq($sformatf("s1_addr_c%0d", c),  32'(avm_address), 32'(c - 1));
            check_eq($sformatf("s1_data_c%0d", c),  avm_writedata,    32'(c - 1));
            check_eq($sformatf("s1_be_c%0d", c),    32'(avm_byteenable), 32'h1);
         end else begin
            check_eq($sformatf("s1_idle_write_c%0d", c), 32'(avm_write),      32'd0);
            check_eq($sformatf("s1_idle_be_c%0d", c),    32'(avm_byteenable), 32'd0);
         end
      end
      check_eq("s1_busy_cycles", 32'(busy_cnt), 32'd7);

      // Two simultaneous requesters from a fresh pointer.
      do_reset();
      req_valid = 2'b11;
      req_data  = {24'h222222, 24'h111111};
      #1 check_eq("s2_ready_first", 32'(req_ready), 32'b01);
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (c == 1) req_valid[0] = 1'b0;
         if (c <= 6) begin
            check_eq($sformatf("s2_r0_addr_c%0d", c), 32'(avm_address), 32'(c - 1));
            check_eq($sformatf("s2_r0_data_c%0d", c), avm_writedata,    32'h1);
         end
         if (c == 7) check_eq("s2_next_write", 32'(avm_write), 32'd0);
         if (c == 7) check_eq("s2_ready_early", 32'(req_ready), 32'b00);
         if (c == 8) check_eq("s2_ready_r1", 32'(req_ready), 32'b10);
         if (c == 9) req_valid[1] = 1'b0;
         if (c >= 9 && c <= 14) begin
            check_eq($sformatf("s2_r1_write_c%0d", c), 32'(avm_write),   32'd1);
            check_eq($sformatf("s2_r1_addr_c%0d", c),  32'(avm_address), 32'(c - 9));
            check_eq($sformatf("s2_r1_data_c%0d", c),  avm_writedata,    32'h2);
         end
      end
      req_valid = 2'b11;
      #1 check_eq("s2_ptr_back_to_0", 32'(req_ready), 32'b01);
      req_valid = 2'b00;

      // Waitrequest held for three cycles on digit 2.
      tick();
      req_valid = 2'b01;
      req_data  = {24'h0, 24'h987654};
      #1 check_eq("s3_ready", 32'(req_ready), 32'b01);
      for (int c = 1; c <= 11; c++) begin
         tick();
         if (c == 1) req_valid = 2'b00;
         if (c == 3) avm_waitrequest = 1'b1;
         if (c == 6) avm_waitrequest = 1'b0;
         if (c <= 9) begin
            exp_addr = (c <= 2) ? 3'(c - 1) : (c <= 6) ? 3'd2 : 3'(c - 4);
            check_eq($sformatf("s3_write_c%0d", c), 32'(avm_write),   32'd1);
            check_eq($sformatf("s3_addr_c%0d", c),  32'(avm_address), 32'(exp_addr));
            check_eq($sformatf("s3_data_c%0d", c),  avm_writedata,    32'(exp_addr) + 32'd4);
         end
         if (c == 10) check_eq("s3_busy_next", 32'(busy), 32'd1);
         if (c == 11) check_eq("s3_busy_done", 32'(busy), 32'd0);
      end

      // Reset asserted while digit 3 is on the bus.
      req_valid = 2'b01;
      req_data  = {24'h0, 24'hFEDCBA};
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 1) req_valid = 2'b00;
      end
      check_eq("s4_pre_addr", 32'(avm_address), 32'd3);
      rst_n = 1'b0;
      #1;
      check_eq("s4_async_write", 32'(avm_write),   32'd0);
      check_eq("s4_async_busy",  32'(busy),        32'd0);
      check_eq("s4_async_addr",  32'(avm_address), 32'd0);
      tick();
      rst_n     = 1'b1;
      req_valid = 2'b10;
      req_data  = {24'h123456, 24'h0};
      #1 check_eq("s4_ready_r1", 32'(req_ready), 32'b10);
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) begin
            req_valid = 2'b00;
            check_eq("s4_first_addr", 32'(avm_address), 32'd0);
            check_eq("s4_first_data", avm_writedata,    32'h6);
         end
      end
      check_eq("s4_idle_busy", 32'(busy), 32'd0);

      // r1 withdraws before it is ever granted.
      req_valid = 2'b11;
      req_data  = {24'h444444, 24'h777777};
      #1 check_eq("s6_ready_r0", 32'(req_ready), 32'b01);
      wr_cnt   = 0;
      rdy1_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 1) begin
            req_valid = 2'b00;
            check_eq("s6_data_r0", avm_writedata, 32'h7);
         end
         #1;
         wr_cnt   += int'(avm_write);
         rdy1_cnt += int'(req_ready[1]);
      end
      check_eq("s6_write_count", 32'(wr_cnt),   32'd6);
      check_eq("s6_r1_ready",    32'(rdy1_cnt), 32'd0);
      check_eq("s6_busy_end",    32'(busy),     32'd0);

`ifdef HEX_SKIP_UNCHANGED_EN
      // Unchanged digits are suppressed on the second update.
      do_reset();
      req_valid = 2'b01;
      req_data  = {24'h0, 24'hABCDEF};
      wr_cnt    = 0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) req_valid = 2'b00;
         wr_cnt += int'(avm_write);
      end
      check_eq("sk_first_writes", 32'(wr_cnt), 32'd6);
      req_valid = 2'b01;
      req_data  = {24'h0, 24'hABCDE0};
      #1 check_eq("sk_ready", 32'(req_ready), 32'b01);
      wr_cnt = 0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) begin
            req_valid = 2'b00;
            check_eq("sk_addr0", 32'(avm_address), 32'd0);
            check_eq("sk_data0", avm_writedata,    32'd0);
         end
         if (c == 7) check_eq("sk_busy_next", 32'(busy), 32'd1);
         wr_cnt += int'(avm_write);
      end
      check_eq("sk_second_writes", 32'(wr_cnt), 32'd1);
      check_eq("sk_busy_end",      32'(busy),   32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
